// File: rtl/spi_main_arbiter.sv
// Round-robin arbiter that shares one SPI main among NREQ requesters.
// The granted requester's byte and {CKP,CPH} are latched at grant time and
// held for the whole transfer. Completion is tracked from the main's CS line.
//
// Handshake: req[i] is a level request. Requester i is being served while
// gnt[i] is high. Every grant ends with exactly one done pulse (with err and
// done_id valid in that same cycle), unless reset intervenes. req[i] may drop
// once gnt[i] is seen; a req still high after done counts as a new request.
module spi_main_arbiter #(
    parameter int NREQ        = 4,
    parameter int IDW         = 2,
    parameter int SETUP_CYC   = 2,
    parameter int START_WAIT  = 4,
    parameter int TIMEOUT_CYC = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [2*NREQ-1:0] req_mode,
    input  logic              spi_cs,
    output logic              spi_start,
    output logic [7:0]        spi_data,
    output logic              spi_ckp,
    output logic              spi_cph,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [IDW-1:0]    done_id,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_START = 3'd2,
        S_BUSY  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [7:0]     SETUP_END = 8'(SETUP_CYC - 1);
    localparam logic [7:0]     START_END = 8'(START_WAIT - 1);
    localparam logic [7:0]     BUSY_END  = 8'(TIMEOUT_CYC - 1);
    localparam logic [IDW-1:0] LAST_RST  = IDW'(NREQ - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_cnt;
    logic [7:0]      w_cnt_nxt;
    logic [IDW-1:0]  r_last;
    logic [IDW-1:0]  w_last_nxt;
    logic [IDW-1:0]  r_idx;
    logic [IDW-1:0]  w_idx_nxt;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] w_gnt_nxt;
    logic            r_start;
    logic            w_start_nxt;
    logic            r_done;
    logic            w_done_nxt;
    logic            r_err;
    logic            w_err_nxt;
    logic [7:0]      r_data;
    logic            r_ckp;
    logic            r_cph;
    logic            w_load;
    logic            w_pick_vld;
    logic [IDW-1:0]  w_pick_idx;
    logic [7:0]      w_sel_data;
    logic [1:0]      w_sel_mode;

    // Round-robin pick: first requesting index after the last served one
    always_comb begin
        logic [IDW-1:0] cand;
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        cand       = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDW'((int'(r_last) + i) % NREQ);
            if (!w_pick_vld && req[cand]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = cand;
            end
        end
    end

    // Select the picked requester's byte and mode for latching
    always_comb begin
        w_sel_data = '0;
        w_sel_mode = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick_idx == IDW'(i)) begin
                w_sel_data = req_data[8*i +: 8];
                w_sel_mode = req_mode[2*i +: 2];
            end
        end
    end

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_idx_nxt   = r_idx;
        w_gnt_nxt   = r_gnt;
        w_start_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = w_pick_idx;
                    w_gnt_nxt   = NREQ'(1) << w_pick_idx;
                    w_load      = 1'b1;
                end
            end
            S_SETUP: begin
                if (r_cnt == SETUP_END) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                    w_start_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_START: begin
                if (!spi_cs) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == START_END) begin
                    // Main never pulled CS low: abort
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_gnt_nxt   = '0;
                    w_last_nxt  = r_idx;
                end else begin
                    w_cnt_nxt   = r_cnt + 8'd1;
                    w_start_nxt = 1'b1;
                end
            end
            S_BUSY: begin
                if (spi_cs) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                    w_gnt_nxt   = '0;
                    w_last_nxt  = r_idx;
                end else if (r_cnt == BUSY_END) begin
                    // CS stuck low: abort
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_gnt_nxt   = '0;
                    w_last_nxt  = r_idx;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Control, counter and latched SPI settings
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_last  <= LAST_RST;
            r_idx   <= '0;
            r_gnt   <= '0;
            r_start <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_data  <= '0;
            r_ckp   <= 1'b0;
            r_cph   <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_idx   <= w_idx_nxt;
            r_gnt   <= w_gnt_nxt;
            r_start <= w_start_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            if (w_load) begin
                r_data <= w_sel_data;
                r_ckp  <= w_sel_mode[1];
                r_cph  <= w_sel_mode[0];
            end
        end
    end

    assign spi_start = r_start;
    assign spi_data  = r_data;
    assign spi_ckp   = r_ckp;
    assign spi_cph   = r_cph;
    assign gnt       = r_gnt;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign err       = r_err;
    assign done_id   = r_done ? r_idx : '0;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_spi_main_arbiter.sv
// Bench for spi_main_arbiter: fixed vector table, reset-in-transfer sequence,
// and randomized transfers checked against a transaction-level model.
module tb_spi_main_arbiter;

    localparam int NREQ        = 4;
    localparam int IDW         = 2;
    localparam int SETUP_CYC   = 2;
    localparam int START_WAIT  = 4;
    localparam int TIMEOUT_CYC = 200;

    localparam logic [8*NREQ-1:0] DEF_DATA = 32'hC3_5A_3C_A5;
    localparam logic [2*NREQ-1:0] DEF_MODE = 8'b11_10_01_00;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [2*NREQ-1:0] req_mode;
    logic              spi_cs;
    logic              spi_start;
    logic [7:0]        spi_data;
    logic              spi_ckp;
    logic              spi_cph;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              done;
    logic              err;
    logic [IDW-1:0]    done_id;
    logic [2:0]        dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;
    int m_last = NREQ - 1;
    logic [IDW-1:0] exp_q[$];

    typedef struct {
        logic [NREQ-1:0] req_v;
        int              d;
        int              len;
        bit              chg;
        int              exp_idx;
        bit              exp_err;
        int              exp_sl;
        int              exp_dk;
    } vec_t;

    vec_t vecs[12];

    spi_main_arbiter #(
        .NREQ(NREQ), .IDW(IDW), .SETUP_CYC(SETUP_CYC),
        .START_WAIT(START_WAIT), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_mode(req_mode),
        .spi_cs(spi_cs), .spi_start(spi_start), .spi_data(spi_data),
        .spi_ckp(spi_ckp), .spi_cph(spi_cph), .gnt(gnt), .busy(busy),
        .done(done), .err(err), .done_id(done_id), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Hang guard
    initial begin
        #400000;
        $display("FAIL watchdog: time limit hit, dbg_state=%0d, required run to end", dbg_state);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: first requester after 'last' in circular order
    function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
        for (int j = 1; j <= NREQ; j++) begin
            if (r[(last + j) % NREQ]) return (last + j) % NREQ;
        end
        return 0;
    endfunction

    // Model: start is high until CS is seen low, at most START_WAIT cycles
    function automatic int exp_sl_f(input int d);
        return (d < START_WAIT) ? d + 1 : START_WAIT;
    endfunction

    function automatic bit exp_err_f(input int d, input int len);
        return (d >= START_WAIT) || (len > TIMEOUT_CYC);
    endfunction

    // Model: done arrives after the start phase plus min(len, TIMEOUT) busy cycles
    function automatic int exp_dk_f(input int d, input int len);
        if (d >= START_WAIT) return START_WAIT;
        return d + ((len < TIMEOUT_CYC) ? len : TIMEOUT_CYC) + 1;
    endfunction

    // One transfer. Called at a tick while the DUT is idle. CS goes low d
    // cycles after start is first seen and stays low for len cycles.
    task automatic run_xfer(input logic [NREQ-1:0] req_v, input int d, input int len,
                            input bit chg, input bit drop, input bit exp_err,
                            input int exp_sl, input int exp_dk,
                            input logic [7:0] exp_data, input logic [1:0] exp_mode);
        logic [IDW-1:0]  exp_id;
        logic [NREQ-1:0] exp_oh;
        logic            got_err;
        logic [IDW-1:0]  got_id;
        logic [NREQ-1:0] got_gnt;
        bit              stable;
        int              w, k, sl, dk;
        exp_id  = exp_q.pop_front();
        exp_oh  = NREQ'(1) << exp_id;
        got_err = 1'bx;
        got_id  = 'x;
        got_gnt = 'x;
        req     = req_v;
        spi_cs  = 1'b1;
        w = 0;
        do begin
            tick();
            w++;
        end while (gnt == '0 && w < 20);
        check("grant_lat", w, 1);
        check("gnt_onehot", gnt, exp_oh);
        check("grant_data", spi_data, exp_data);
        check("grant_mode", {spi_ckp, spi_cph}, exp_mode);
        check("grant_busy", busy, 1);
        if (gnt == '0) return;
        w = 0;
        while (!spi_start && w < 20) begin
            tick();
            w++;
        end
        check("setup_lat", w, SETUP_CYC);
        if (!spi_start) return;
        k = 0; sl = 0; dk = -1; stable = 1'b1;
        while (dk < 0 && k < 500) begin
            if (spi_start) sl++;
            if (done) begin
                dk      = k;
                got_err = err;
                got_id  = done_id;
                got_gnt = gnt;
            end else begin
                if (gnt !== exp_oh || spi_data !== exp_data ||
                    {spi_ckp, spi_cph} !== exp_mode || busy !== 1'b1) stable = 1'b0;
                if (chg && k == d + 1) begin
                    req_data = $urandom;
                    req_mode = 8'($urandom);
                end
                if (drop && k == d + 1) req = '0;
                spi_cs = !((k >= d) && (k < d + len));
                tick();
                k++;
            end
        end
        spi_cs = 1'b1;
        check("start_len", sl, exp_sl);
        check("done_cycle", dk, exp_dk);
        check("done_err", got_err, exp_err);
        check("done_id", got_id, exp_id);
        check("gnt_at_done", got_gnt, 0);
        check("hold_stable", stable, 1);
        tick();
        check("done_one_cycle", done, 0);
        check("err_cleared", err, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        vecs[0]  = '{4'b0001, 3, 70,  1'b0, 0, 1'b0, 4, 74};
        vecs[1]  = '{4'b1000, 0, 1,   1'b0, 3, 1'b0, 1, 2};
        vecs[2]  = '{4'b1011, 1, 5,   1'b0, 0, 1'b0, 2, 7};
        vecs[3]  = '{4'b1011, 0, 1,   1'b0, 1, 1'b0, 1, 2};
        vecs[4]  = '{4'b1011, 2, 10,  1'b0, 3, 1'b0, 3, 13};
        vecs[5]  = '{4'b1011, 1, 5,   1'b1, 0, 1'b0, 2, 7};
        vecs[6]  = '{4'b1011, 3, 3,   1'b0, 1, 1'b0, 4, 7};
        vecs[7]  = '{4'b1011, 1, 5,   1'b1, 3, 1'b0, 2, 7};
        vecs[8]  = '{4'b0100, 9, 1,   1'b0, 2, 1'b1, 4, 4};
        vecs[9]  = '{4'b0011, 1, 999, 1'b0, 0, 1'b1, 2, 202};
        vecs[10] = '{4'b0011, 0, 200, 1'b0, 1, 1'b0, 1, 201};
        vecs[11] = '{4'b0001, 0, 201, 1'b0, 0, 1'b1, 1, 201};

        // Reset
        rst      = 1'b0;
        req      = '0;
        spi_cs   = 1'b1;
        req_data = DEF_DATA;
        req_mode = DEF_MODE;
        repeat (3) tick();
        check("rst_start", spi_start, 0);
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_data", spi_data, 0);
        check("rst_mode", {spi_ckp, spi_cph}, 0);
        rst = 1'b1;
        tick();

        // Vector table
        for (int i = 0; i < 12; i++) begin
            req_data = DEF_DATA;
            req_mode = DEF_MODE;
            exp_q.push_back(IDW'(vecs[i].exp_idx));
            run_xfer(vecs[i].req_v, vecs[i].d, vecs[i].len, vecs[i].chg, 1'b0,
                     vecs[i].exp_err, vecs[i].exp_sl, vecs[i].exp_dk,
                     8'(DEF_DATA >> (8 * vecs[i].exp_idx)),
                     2'(DEF_MODE >> (2 * vecs[i].exp_idx)));
            m_last = vecs[i].exp_idx;
        end

        // Asynchronous reset in the middle of a busy transfer
        begin
            int  w;
            bit  seen_done;
            req_data = DEF_DATA;
            req_mode = DEF_MODE;
            req      = 4'b0010;
            spi_cs   = 1'b1;
            w = 0;
            while (!spi_start && w < 20) begin
                tick();
                w++;
            end
            check("rstseq_start", spi_start, 1);
            spi_cs = 1'b0;
            repeat (5) tick();
            check("rstseq_in_busy", {busy, spi_start}, 2'b10);
            #2;
            rst = 1'b0;
            #1;
            check("rstseq_start0", spi_start, 0);
            check("rstseq_gnt0", gnt, 0);
            check("rstseq_busy0", busy, 0);
            check("rstseq_done0", done, 0);
            seen_done = 1'b0;
            repeat (3) begin
                tick();
                if (done) seen_done = 1'b1;
            end
            check("rstseq_no_done", seen_done, 0);
            spi_cs = 1'b1;
            rst    = 1'b1;
            m_last = NREQ - 1;
            exp_q.push_back(IDW'(0));
            run_xfer(4'b0011, 1, 5, 1'b0, 1'b0, 1'b0, 2, 7,
                     DEF_DATA[7:0], DEF_MODE[1:0]);
            m_last = 0;
        end

        // Randomized transfers against the transaction-level model
        for (int n = 0; n < 30; n++) begin
            logic [NREQ-1:0] rv;
            int              d, len, idx;
            bit              chg, drop;
            logic [7:0]      xd;
            logic [1:0]      xm;
            rv       = NREQ'($urandom_range(1, 15));
            req_data = $urandom;
            req_mode = 8'($urandom);
            d        = $urandom_range(0, 5);
            len      = ($urandom_range(0, 7) == 0) ? $urandom_range(199, 201) : $urandom_range(1, 20);
            chg      = ($urandom_range(0, 1) == 1);
            drop     = ($urandom_range(0, 3) == 0);
            idx      = rr_pick(rv, m_last);
            xd       = 8'(req_data >> (8 * idx));
            xm       = 2'(req_mode >> (2 * idx));
            exp_q.push_back(IDW'(idx));
            run_xfer(rv, d, len, chg, drop, exp_err_f(d, len), exp_sl_f(d),
                     exp_dk_f(d, len), xd, xm);
            m_last = idx;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
